// File: rtl/pong_pkg.sv
// Shared pong constants, paddle FSM encoding and AI target helper,
// used by the paddle and ball controllers.
package pong_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned TOP_MARGIN  = 25;
  localparam int unsigned PADDLE_H    = 72;
  localparam int unsigned Y_MAX       = SCREEN_H - TOP_MARGIN - PADDLE_H;
  localparam int unsigned Y_CENTER    = 191;
  // AI tracks the ball only once it is in the right half of the field
  localparam int unsigned AI_X_THRESH = SCREEN_W / 2;

  typedef enum logic [1:0] {
    PAD_IDLE = 2'd0,
    PAD_UP   = 2'd1,
    PAD_DOWN = 2'd2
  } paddle_state_e;

  // Paddle top that centres the paddle on ball_y, clamped to [0, ymax]
  function automatic logic [9:0] ai_target(input logic [9:0] ball_y,
                                           input logic [9:0] offset,
                                           input logic [9:0] ymax);
    logic [9:0] diff;
    diff = ball_y - offset;
    if (ball_y < offset) return '0;
    else if (diff > ymax) return ymax;
    else return diff;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a refresh-tick debouncer for one button.
module button_debounce #(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw button into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end

  // Flip the level only after DEB_TICKS consecutive disagreeing ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (tick_i) begin
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(DEB_TICKS - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/paddle_controller.sv
// Two paddles: human paddles with debounced buttons, speed-ramping IDLE/UP/DOWN
// FSMs and saturating motion; paddle 2 optionally driven by a ball-tracking AI.
module paddle_controller
  import pong_pkg::*;
#(
  parameter int unsigned TOP_MARGIN = pong_pkg::TOP_MARGIN,
  parameter int unsigned PADDLE_H   = pong_pkg::PADDLE_H,
  parameter int unsigned Y_MAX      = pong_pkg::Y_MAX,
  parameter int unsigned Y_CENTER   = pong_pkg::Y_CENTER,
  parameter int unsigned DEB_TICKS  = 4,
  parameter int unsigned RAMP_TICKS = 8,
  parameter int unsigned MAX_SPEED  = 4,
  parameter int unsigned AI_SPEED   = 3,
  parameter int unsigned AI_PERIOD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       game_active,
  input  logic       game_over,
  input  logic       ai_enable,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       ai_active
);

  localparam int unsigned SPW = $clog2(MAX_SPEED + 1);
  localparam int unsigned RMW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int unsigned AIW = (AI_PERIOD > 1) ? $clog2(AI_PERIOD) : 1;
  localparam logic [9:0]  YMAX_L  = 10'(Y_MAX);
  localparam logic [9:0]  YCTR_L  = 10'(Y_CENTER);
  localparam logic [9:0]  AI_OFS  = 10'(TOP_MARGIN + PADDLE_H / 2);
  localparam logic [9:0]  AI_STEP = 10'(AI_SPEED);
  localparam logic [9:0]  AI_X    = 10'(AI_X_THRESH);

  logic [1:0]     up_lvl, dn_lvl;
  paddle_state_e  st_q    [2];
  paddle_state_e  req_st  [2];
  logic [SPW-1:0] speed_q [2];
  logic [RMW-1:0] ramp_q  [2];
  logic [9:0]     pos_q   [2];
  logic [9:0]     step    [2];
  logic [9:0]     mov     [2];
  logic           ai_active_q;
  logic [AIW-1:0] ai_div_q;
  logic [9:0]     tgt_q, tgt_calc, tgt_eff, ai_pos;

  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_p1_up (
    .clk(clk), .reset(reset), .tick_i(refresh_tick), .btn_i(p1_up), .level_o(up_lvl[0]));
  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_p1_down (
    .clk(clk), .reset(reset), .tick_i(refresh_tick), .btn_i(p1_down), .level_o(dn_lvl[0]));
  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_p2_up (
    .clk(clk), .reset(reset), .tick_i(refresh_tick), .btn_i(p2_up), .level_o(up_lvl[1]));
  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_p2_down (
    .clk(clk), .reset(reset), .tick_i(refresh_tick), .btn_i(p2_down), .level_o(dn_lvl[1]));

  // Requested FSM state from debounced levels, with game_over / AI overrides
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      req_st[i] = PAD_IDLE;
      if (up_lvl[i] && !dn_lvl[i])      req_st[i] = PAD_UP;
      else if (dn_lvl[i] && !up_lvl[i]) req_st[i] = PAD_DOWN;
    end
    if (game_over || ai_active_q) req_st[1] = PAD_IDLE;
    if (game_over)                req_st[0] = PAD_IDLE;
  end

  // Saturating human-paddle motion from the registered state and speed
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      step[i] = 10'(speed_q[i]);
      mov[i]  = pos_q[i];
      case (st_q[i])
        PAD_UP:   mov[i] = (pos_q[i] >= step[i]) ? pos_q[i] - step[i] : '0;
        PAD_DOWN: mov[i] = (YMAX_L - pos_q[i] >= step[i]) ? pos_q[i] + step[i] : YMAX_L;
        default:  mov[i] = pos_q[i];
      endcase
    end
  end

  // AI target and capped step; a sampling tick steers toward the fresh target
  always_comb begin
    tgt_calc = (ball_x >= AI_X) ? ai_target(ball_y, AI_OFS, YMAX_L) : YCTR_L;
    tgt_eff  = (ai_div_q == '0) ? tgt_calc : tgt_q;
    ai_pos   = pos_q[1];
    if (tgt_eff > pos_q[1])
      ai_pos = (tgt_eff - pos_q[1] > AI_STEP) ? pos_q[1] + AI_STEP : tgt_eff;
    else if (tgt_eff < pos_q[1])
      ai_pos = (pos_q[1] - tgt_eff > AI_STEP) ? pos_q[1] - AI_STEP : tgt_eff;
  end

  // Paddle FSMs, speed ramp and positions, all advanced on refresh_tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]    <= PAD_IDLE;
        speed_q[i] <= SPW'(1);
        ramp_q[i]  <= '0;
        pos_q[i]   <= YCTR_L;
      end
    end else if (refresh_tick) begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i] <= req_st[i];
        if (req_st[i] == PAD_IDLE || req_st[i] != st_q[i]) begin
          speed_q[i] <= SPW'(1);
          ramp_q[i]  <= '0;
        end else if (ramp_q[i] == RMW'(RAMP_TICKS - 1)) begin
          ramp_q[i] <= '0;
          if (speed_q[i] < SPW'(MAX_SPEED)) speed_q[i] <= speed_q[i] + SPW'(1);
        end else begin
          ramp_q[i] <= ramp_q[i] + RMW'(1);
        end
      end
      if (game_over) begin
        pos_q[0] <= YCTR_L;
        pos_q[1] <= YCTR_L;
      end else if (game_active) begin
        pos_q[0] <= mov[0];
        pos_q[1] <= ai_active_q ? ai_pos : mov[1];
      end
    end
  end

  // AI sampling divider and held target; divider parks at 0 while AI is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ai_div_q <= '0;
      tgt_q    <= YCTR_L;
    end else if (refresh_tick) begin
      if (!ai_active_q) begin
        ai_div_q <= '0;
      end else begin
        tgt_q    <= tgt_eff;
        ai_div_q <= (ai_div_q == AIW'(AI_PERIOD - 1)) ? '0 : ai_div_q + AIW'(1);
      end
    end
  end

  // Registered copy of the AI enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ai_active_q <= 1'b0;
    else       ai_active_q <= ai_enable;
  end

  assign paddle1_y = pos_q[0];
  assign paddle2_y = pos_q[1];
  assign ai_active = ai_active_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Self-checking bench for paddle_controller against a tick-level behavioural model.
module tb_paddle_controller;

  localparam int DEB = 4, RAMP = 8, MAXSP = 4, AISP = 3, YMAX = 383, YCTR = 191;

  logic       clk = 1'b0;
  logic       reset = 1'b0, refresh_tick = 1'b0, game_active = 1'b1, game_over = 1'b0;
  logic       ai_enable = 1'b0, p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0;
  logic [9:0] paddle1_y, paddle2_y;
  logic       ai_active;

  int checks = 0, errors = 0;

  // model state
  int m_pos[2], m_dir[2], m_run[2], m_deb[4], m_strk[4], m_ai_cnt, m_tgt;

  paddle_controller dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .game_active(game_active),
    .game_over(game_over), .ai_enable(ai_enable), .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ai_active(ai_active));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int ai_tgt(int bx, int by);
    if (bx < 320) return YCTR;
    if (by < 61) return 0;
    return (by - 61 > YMAX) ? YMAX : by - 61;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_pos[i] = YCTR; m_dir[i] = 0; m_run[i] = 0; end
    for (int k = 0; k < 4; k++) begin m_deb[k] = 0; m_strk[k] = 0; end
    m_ai_cnt = 0;
    m_tgt = YCTR;
  endtask

  // One refresh tick on the DUT, then advance the model by the same tick
  task automatic tick();
    int npos[2], req[2], b[4], sp, d;
    repeat (3) @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
    b[0] = int'(p1_up); b[1] = int'(p1_down); b[2] = int'(p2_up); b[3] = int'(p2_down);
    for (int i = 0; i < 2; i++) begin
      sp = 1 + m_run[i] / RAMP;
      if (sp > MAXSP) sp = MAXSP;
      npos[i] = m_pos[i] + m_dir[i] * sp;
      if (npos[i] < 0) npos[i] = 0;
      if (npos[i] > YMAX) npos[i] = YMAX;
    end
    if (ai_enable) begin
      if (m_ai_cnt % 2 == 0) m_tgt = ai_tgt(int'(ball_x), int'(ball_y));
      m_ai_cnt++;
      d = m_tgt - m_pos[1];
      if (d > AISP) d = AISP;
      if (d < -AISP) d = -AISP;
      npos[1] = m_pos[1] + d;
    end else begin
      m_ai_cnt = 0;
    end
    if (game_over) begin npos[0] = YCTR; npos[1] = YCTR; end
    else if (!game_active) begin npos[0] = m_pos[0]; npos[1] = m_pos[1]; end
    for (int i = 0; i < 2; i++) begin
      req[i] = 0;
      if (m_deb[2*i] == 1 && m_deb[2*i+1] == 0) req[i] = -1;
      if (m_deb[2*i] == 0 && m_deb[2*i+1] == 1) req[i] = 1;
    end
    if (game_over) begin req[0] = 0; req[1] = 0; end
    if (ai_enable) req[1] = 0;
    for (int i = 0; i < 2; i++) begin
      if (req[i] != 0 && req[i] == m_dir[i]) m_run[i]++;
      else m_run[i] = 0;
      m_dir[i] = req[i];
      m_pos[i] = npos[i];
    end
    for (int k = 0; k < 4; k++) begin
      if (b[k] != m_deb[k]) begin
        m_strk[k]++;
        if (m_strk[k] == DEB) begin m_deb[k] = b[k]; m_strk[k] = 0; end
      end else begin
        m_strk[k] = 0;
      end
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0; ai_enable = 0;
    game_active = 1; game_over = 0;
    assert_reset();
    checks++; if (paddle1_y !== 10'd191) begin errors++; $display("FAIL reset_p1: got %0d expected 191", paddle1_y); end
    checks++; if (paddle2_y !== 10'd191) begin errors++; $display("FAIL reset_p2: got %0d expected 191", paddle2_y); end
    checks++; if (ai_active !== 1'b0) begin errors++; $display("FAIL reset_ai: got %0b expected 0", ai_active); end
    release_reset();
  endtask

  task automatic test_hold_down();
    int exp;
    p1_down = 1;
    for (int t = 1; t <= 90; t++) begin
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0])) begin errors++; $display("FAIL down_model t=%0d: got %0d expected %0d", t, paddle1_y, m_pos[0]); end
      exp = -1;
      if (t == 5) exp = 191;
      if (t == 6) exp = 192;
      if (t == 13) exp = 199;
      if (t == 14) exp = 201;
      if (t == 90) exp = 383;
      if (exp >= 0) begin
        checks++; if (paddle1_y !== 10'(exp)) begin errors++; $display("FAIL down_profile t=%0d: got %0d expected %0d", t, paddle1_y, exp); end
      end
    end
    p1_down = 0;
  endtask

  task automatic test_up_floor();
    p1_up = 1;
    for (int t = 1; t <= 130; t++) begin
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0])) begin errors++; $display("FAIL up_model t=%0d: got %0d expected %0d", t, paddle1_y, m_pos[0]); end
    end
    checks++; if (paddle1_y !== 10'd0) begin errors++; $display("FAIL up_floor: got %0d expected 0", paddle1_y); end
    p1_up = 0;
  endtask

  task automatic test_glitch();
    assert_reset();
    release_reset();
    p1_up = 1;
    for (int t = 1; t <= 9; t++) begin
      if (t == 4) p1_up = 0;
      tick();
      checks++; if (paddle1_y !== 10'd191) begin errors++; $display("FAIL glitch t=%0d: got %0d expected 191", t, paddle1_y); end
    end
  endtask

  task automatic test_ai();
    assert_reset();
    release_reset();
    ai_enable = 1; ball_x = 10'd400; ball_y = 10'd300;
    for (int t = 1; t <= 25; t++) begin
      p2_up = 1'($urandom_range(0, 1)); p2_down = 1'($urandom_range(0, 1));
      tick();
      checks++; if (paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL ai_track t=%0d: got %0d expected %0d", t, paddle2_y, m_pos[1]); end
    end
    checks++; if (paddle2_y !== 10'd239) begin errors++; $display("FAIL ai_target239: got %0d expected 239", paddle2_y); end
    checks++; if (ai_active !== 1'b1) begin errors++; $display("FAIL ai_active: got %0b expected 1", ai_active); end
    ball_x = 10'd100;
    for (int t = 1; t <= 25; t++) begin
      tick();
      checks++; if (paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL ai_home t=%0d: got %0d expected %0d", t, paddle2_y, m_pos[1]); end
    end
    checks++; if (paddle2_y !== 10'd191) begin errors++; $display("FAIL ai_center: got %0d expected 191", paddle2_y); end
    ball_x = 10'd400; ball_y = 10'd40;
    for (int t = 1; t <= 70; t++) begin
      tick();
      checks++; if (paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL ai_top t=%0d: got %0d expected %0d", t, paddle2_y, m_pos[1]); end
    end
    checks++; if (paddle2_y !== 10'd0) begin errors++; $display("FAIL ai_target0: got %0d expected 0", paddle2_y); end
    ai_enable = 0; p2_up = 0; p2_down = 0;
  endtask

  task automatic test_freeze_and_over();
    logic [9:0] held1, held2;
    assert_reset();
    release_reset();
    p1_down = 1; p2_up = 1;
    for (int t = 1; t <= 12; t++) tick();
    game_active = 0;
    held1 = paddle1_y; held2 = paddle2_y;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++; if (paddle1_y !== held1 || paddle2_y !== held2) begin errors++; $display("FAIL freeze t=%0d: got %0d/%0d expected %0d/%0d", t, paddle1_y, paddle2_y, held1, held2); end
    end
    game_active = 1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0]) || paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL resume t=%0d: got %0d/%0d expected %0d/%0d", t, paddle1_y, paddle2_y, m_pos[0], m_pos[1]); end
    end
    game_over = 1;
    tick();
    game_over = 0;
    checks++; if (paddle1_y !== 10'd191 || paddle2_y !== 10'd191) begin errors++; $display("FAIL game_over: got %0d/%0d expected 191/191", paddle1_y, paddle2_y); end
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0]) || paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL after_over t=%0d: got %0d/%0d expected %0d/%0d", t, paddle1_y, paddle2_y, m_pos[0], m_pos[1]); end
    end
    p1_down = 0; p2_up = 0;
  endtask

  task automatic test_reset_mid();
    p1_down = 1;
    for (int t = 1; t <= 20; t++) tick();
    assert_reset();
    checks++; if (paddle1_y !== 10'd191 || paddle2_y !== 10'd191) begin errors++; $display("FAIL reset_mid: got %0d/%0d expected 191/191", paddle1_y, paddle2_y); end
    release_reset();
    for (int t = 1; t <= 15; t++) begin
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0])) begin errors++; $display("FAIL post_reset t=%0d: got %0d expected %0d", t, paddle1_y, m_pos[0]); end
      if (t == 6) begin
        checks++; if (paddle1_y !== 10'd192) begin errors++; $display("FAIL post_reset_speed: got %0d expected 192", paddle1_y); end
      end
    end
    p1_down = 0;
  endtask

  task automatic test_random();
    assert_reset();
    release_reset();
    for (int t = 1; t <= 400; t++) begin
      if ($urandom_range(0, 7) == 0) p1_up = ~p1_up;
      if ($urandom_range(0, 7) == 0) p1_down = ~p1_down;
      if ($urandom_range(0, 7) == 0) p2_up = ~p2_up;
      if ($urandom_range(0, 7) == 0) p2_down = ~p2_down;
      if ($urandom_range(0, 39) == 0) ai_enable = ~ai_enable;
      game_active = ($urandom_range(0, 15) != 0);
      game_over = ($urandom_range(0, 31) == 0);
      ball_x = 10'($urandom_range(0, 639));
      ball_y = 10'($urandom_range(0, 1023));
      tick();
      checks++; if (paddle1_y !== 10'(m_pos[0])) begin errors++; $display("FAIL rand_p1 t=%0d: got %0d expected %0d", t, paddle1_y, m_pos[0]); end
      checks++; if (paddle2_y !== 10'(m_pos[1])) begin errors++; $display("FAIL rand_p2 t=%0d: got %0d expected %0d", t, paddle2_y, m_pos[1]); end
      checks++; if (ai_active !== ai_enable) begin errors++; $display("FAIL rand_ai t=%0d: got %0b expected %0b", t, ai_active, ai_enable); end
    end
    game_over = 0; game_active = 1; ai_enable = 0;
    p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_down();
    test_up_floor();
    test_glitch();
    test_ai();
    test_freeze_and_over();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
